ov7670_cfg_sequencer: RTL and testbench

OV7670_CFG_SEQUENCER -- requirements
Module: ov7670_cfg_sequencer

---
 rtl/ov7670_cfg_pkg.sv | 29 ++
 rtl/cfg_delay_timer.sv | 34 +++
 rtl/ov7670_cfg_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_ov7670_cfg_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_pkg
// Shared definitions for the OV7670 configuration sequencer: FSM state
// encoding, the two reserved table words, and the delay-length computation.
// ---------------------------------------------------------------------------
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_READY,
    ST_RT_WAIT
  } cfg_state_t;

  // Reserved table words: terminate the run / insert a settle delay.
  localparam logic [15:0] END_MARK = 16'hFFFF;
  localparam logic [15:0] DLY_MARK = 16'hFFF0;

  // Number of clock cycles spent on a delay marker.
  function automatic int unsigned delay_cycles(input int unsigned clk_freq,
                                               input int unsigned settle_us);
    return (clk_freq / 32'd1000000) * settle_us;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// ---------------------------------------------------------------------------
// cfg_delay_timer
// Loadable down-counter that stops at zero.
//   i_clk      clock
//   i_rst_n    async active-low reset (counter cleared to 0)
//   i_load     load i_value this cycle
//   i_value    start value; the counter reads 0 after i_value further cycles
//   o_expired  counter is at 0
// ---------------------------------------------------------------------------
module cfg_delay_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_sequencer
// Walks a {reg,val} table from an external ROM and hands each entry to an
// external SCCB write engine. Word FFF0 inserts a settle delay, FFFF ends the
// run (so does wrapping the address). After the run, single runtime writes
// are accepted through a valid/ready handshake.
//   i_clk / i_rst_n          clock, async active-low reset
//   i_start                  level; rising edge starts or restarts the run
//   o_rom_addr / i_rom_data  table address; data valid one cycle later
//   o_wr_start               1-cycle pulse to the write engine
//   o_wr_reg / o_wr_val      register address/value, held until i_wr_done
//   i_wr_busy / i_wr_done    engine busy level / completion pulse
//   i_req_valid/_reg/_val    runtime write request
//   o_req_ready              runtime request accepted when high with valid
//   o_done                   table run complete
//   o_busy                   sequencer not in IDLE or READY
// ---------------------------------------------------------------------------
module ov7670_cfg_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned SETTLE_US = 1000,
  parameter int unsigned ROM_AW    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_wr_start,
  output logic [7:0]        o_wr_reg,
  output logic [7:0]        o_wr_val,
  input  logic              i_wr_busy,
  input  logic              i_wr_done,
  input  logic              i_req_valid,
  input  logic [7:0]        i_req_reg,
  input  logic [7:0]        i_req_val,
  output logic              o_req_ready,
  output logic              o_done,
  output logic              o_busy
);

  localparam int unsigned DLY_CYC = delay_cycles(CLK_FREQ, SETTLE_US);
  localparam int unsigned DLY_W   = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
  // The DELAY state lasts load+1 cycles, so load one less than the length.
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((DLY_CYC == 0) ? 0 : DLY_CYC - 1);
  localparam logic [ROM_AW-1:0] IDX_MAX = '1;

  cfg_state_t        r_state;
  logic [ROM_AW-1:0] r_idx;
  logic              r_start_d;
  logic              r_last;      // delay marker sat in the last table slot
  logic              r_wr_start;
  logic [7:0]        r_wr_reg;
  logic [7:0]        r_wr_val;
  logic              r_done;
  logic              r_busy;

  logic              w_start_edge;
  logic              w_dly_load;
  logic              w_dly_expired;
  logic              w_is_end;
  logic              w_is_dly;

  assign w_start_edge = i_start & ~r_start_d;
  assign w_is_end     = (i_rom_data == END_MARK);
  assign w_is_dly     = (i_rom_data == DLY_MARK);
  assign w_dly_load   = (r_state == ST_DECODE) && w_is_dly;

  cfg_delay_timer #(
    .W (DLY_W)
  ) u_delay (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_dly_load),
    .i_value   (DLY_LOAD),
    .o_expired (w_dly_expired)
  );

  // Edge register runs in every state so a level held across a run never
  // looks like a fresh edge once READY is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= i_start;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_wr_start <= 1'b0;
      r_wr_reg   <= 8'h00;
      r_wr_val   <= 8'h00;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_edge) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end

        ST_FETCH: r_state <= ST_DECODE;

        ST_DECODE: begin
          if (w_is_end) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_READY;
          end else if (w_is_dly) begin
            r_last  <= (r_idx == IDX_MAX);
            r_idx   <= r_idx + ROM_AW'(1);
            r_state <= ST_DELAY;
          end else begin
            r_wr_reg <= i_rom_data[15:8];
            r_wr_val <= i_rom_data[7:0];
            r_state  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!i_wr_busy) begin
            r_wr_start <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (i_wr_done) begin
            r_idx <= r_idx + ROM_AW'(1);
            if (r_idx == IDX_MAX) begin
              // Address wrap without an end marker terminates the run.
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_READY;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end

        ST_DELAY: begin
          if (w_dly_expired) begin
            if (r_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_READY;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end

        ST_READY: begin
          if (w_start_edge) begin
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end else if (i_req_valid && !i_wr_busy) begin
            r_wr_reg   <= i_req_reg;
            r_wr_val   <= i_req_val;
            r_wr_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_RT_WAIT;
          end
        end

        ST_RT_WAIT: begin
          if (i_wr_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_READY;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: ready is decoded combinationally so the handshake completes in
  // the same cycle and a coincident restart edge can veto acceptance.
  assign o_req_ready = (r_state == ST_READY) && !i_wr_busy && !w_start_edge;

  assign o_rom_addr = r_idx;
  assign o_wr_start = r_wr_start;
  assign o_wr_reg   = r_wr_reg;
  assign o_wr_val   = r_wr_val;
  assign o_done     = r_done;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ov7670_cfg_sequencer
// Two sequencers: A (ROM_AW=8) for table/runtime/reset scenarios and
// B (ROM_AW=2) for the address-wrap case. Each has a ROM and a write-engine
// model that finishes 10 cycles after o_wr_start. Expected writes are queued
// when stimulus is set up and popped against observed writes.
// ---------------------------------------------------------------------------
module tb_ov7670_cfg_sequencer;

  localparam int unsigned CLK_FREQ  = 25000000;
  localparam int unsigned SETTLE_US = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A ----------------
  logic        start_a = 1'b0;
  logic [7:0]  addr_a;
  logic [15:0] rom_data_a;
  logic        wr_start_a;
  logic [7:0]  wr_reg_a, wr_val_a;
  logic        eng_busy_a = 1'b0, eng_done_a = 1'b0;
  int          eng_cnt_a = 0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_reg = 8'h00, req_val = 8'h00;
  logic        req_ready_a, cfg_done_a, cfg_busy_a;
  logic [15:0] rom_a [256];
  assign rom_data_a = rom_a[addr_a];

  // ---------------- instance B ----------------
  logic        start_b = 1'b0;
  logic [1:0]  addr_b;
  logic [15:0] rom_data_b;
  logic        wr_start_b;
  logic [7:0]  wr_reg_b, wr_val_b;
  logic        eng_busy_b = 1'b0, eng_done_b = 1'b0;
  int          eng_cnt_b = 0;
  logic        req_valid_b = 1'b0;
  logic [7:0]  req_reg_b = 8'h00, req_val_b = 8'h00;
  logic        req_ready_b, cfg_done_b, cfg_busy_b;
  logic [15:0] rom_b [4];
  assign rom_data_b = rom_b[addr_b];

  logic [15:0] exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  int          st_cyc_a[$], dn_cyc_a[$];

  ov7670_cfg_sequencer #(.CLK_FREQ(CLK_FREQ), .SETTLE_US(SETTLE_US), .ROM_AW(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
    .o_rom_addr(addr_a), .i_rom_data(rom_data_a),
    .o_wr_start(wr_start_a), .o_wr_reg(wr_reg_a), .o_wr_val(wr_val_a),
    .i_wr_busy(eng_busy_a), .i_wr_done(eng_done_a),
    .i_req_valid(req_valid), .i_req_reg(req_reg), .i_req_val(req_val),
    .o_req_ready(req_ready_a), .o_done(cfg_done_a), .o_busy(cfg_busy_a)
  );

  ov7670_cfg_sequencer #(.CLK_FREQ(CLK_FREQ), .SETTLE_US(SETTLE_US), .ROM_AW(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .o_rom_addr(addr_b), .i_rom_data(rom_data_b),
    .o_wr_start(wr_start_b), .o_wr_reg(wr_reg_b), .o_wr_val(wr_val_b),
    .i_wr_busy(eng_busy_b), .i_wr_done(eng_done_b),
    .i_req_valid(req_valid_b), .i_req_reg(req_reg_b), .i_req_val(req_val_b),
    .o_req_ready(req_ready_b), .o_done(cfg_done_b), .o_busy(cfg_busy_b)
  );

  // Write-engine models: driven on the falling edge, done 10 cycles after start.
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_busy_a = 1'b0; eng_done_a = 1'b0; eng_cnt_a = 0;
    end else begin
      eng_done_a = 1'b0;
      if (eng_busy_a) begin
        eng_cnt_a--;
        if (eng_cnt_a == 0) begin
          eng_busy_a = 1'b0; eng_done_a = 1'b1; dn_cyc_a.push_back(cyc);
        end
      end
      if (wr_start_a) begin
        obs_a.push_back({wr_reg_a, wr_val_a});
        st_cyc_a.push_back(cyc);
        eng_busy_a = 1'b1; eng_cnt_a = 10;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      eng_busy_b = 1'b0; eng_done_b = 1'b0; eng_cnt_b = 0;
    end else begin
      eng_done_b = 1'b0;
      if (eng_busy_b) begin
        eng_cnt_b--;
        if (eng_cnt_b == 0) begin
          eng_busy_b = 1'b0; eng_done_b = 1'b1;
        end
      end
      if (wr_start_b) begin
        obs_b.push_back({wr_reg_b, wr_val_b});
        eng_busy_b = 1'b1; eng_cnt_b = 10;
      end
    end
  end

  task automatic wait_ready_a(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cfg_done_a && !cfg_busy_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ready_b(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cfg_done_b && !cfg_busy_b) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({addr_a, wr_start_a, wr_reg_a, wr_val_a, req_ready_a, cfg_done_a, cfg_busy_a} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_a: addr=%h start=%b reg=%h val=%h rdy=%b done=%b busy=%b, required all 0",
               addr_a, wr_start_a, wr_reg_a, wr_val_a, req_ready_a, cfg_done_a, cfg_busy_a);
    end
    n_cmp++;
    if ({addr_b, wr_start_b, cfg_done_b, cfg_busy_b, req_ready_b} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_b: addr=%h start=%b done=%b busy=%b rdy=%b, required all 0",
               addr_b, wr_start_b, cfg_done_b, cfg_busy_b, req_ready_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    n_cmp++;
    if (cfg_busy_a !== 1'b0 || obs_a.size() != 0) begin
      n_err++;
      $display("FAIL idle_no_start: busy=%b writes=%0d, required 0/0", cfg_busy_a, obs_a.size());
    end
  endtask

  task automatic test_table();
    bit ok;
    logic [15:0] e, g;
    st_cyc_a.delete(); dn_cyc_a.delete();
    exp_a.push_back(16'h1280); exp_a.push_back(16'h3A04);
    @(negedge clk); start_a = 1'b1;
    wait_ready_a(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL table_done: timed out, done=%b required 1", cfg_done_a); end
    repeat (15) @(negedge clk);
    #1;
    n_cmp++;
    if (cfg_done_a !== 1'b1) begin n_err++; $display("FAIL table_done_hold: done=%b required 1", cfg_done_a); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL table_write: no write observed, required %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_err++; $display("FAIL table_write: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (obs_a.size() != 0) begin n_err++; $display("FAIL table_extra: %0d extra writes, required 0", obs_a.size()); obs_a.delete(); end
    // done seen in WAIT, then FETCH, DECODE, 25 DELAY, FETCH, DECODE, ISSUE -> start 31 cycles later
    n_cmp++;
    if (st_cyc_a.size() != 2 || dn_cyc_a.size() < 1) begin
      n_err++; $display("FAIL delay_gap: starts=%0d dones=%0d, required 2/>=1", st_cyc_a.size(), dn_cyc_a.size());
    end else if (st_cyc_a[1] - dn_cyc_a[0] != 31) begin
      n_err++; $display("FAIL delay_gap: got %0d cycles required 31", st_cyc_a[1] - dn_cyc_a[0]);
    end
  endtask

  task automatic test_runtime();
    bit ok;
    logic [15:0] e, g;
    @(negedge clk); start_a = 1'b0;
    exp_a.push_back(16'h5540);
    @(negedge clk); req_valid = 1'b1; req_reg = 8'h55; req_val = 8'h40;
    #1;
    n_cmp++;
    if (req_ready_a !== 1'b1) begin n_err++; $display("FAIL rt_ready: got %b required 1", req_ready_a); end
    @(negedge clk); req_valid = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready_a, wr_start_a, wr_reg_a, wr_val_a, cfg_busy_a} !== {1'b0, 1'b1, 8'h55, 8'h40, 1'b1}) begin
      n_err++;
      $display("FAIL rt_issue: rdy=%b start=%b reg=%h val=%h busy=%b, required 0/1/55/40/1",
               req_ready_a, wr_start_a, wr_reg_a, wr_val_a, cfg_busy_a);
    end
    wait_ready_a(100, ok);
    #1;
    n_cmp++;
    if (!ok || req_ready_a !== 1'b1) begin
      n_err++; $display("FAIL rt_return: ok=%b rdy=%b, required 1/1", ok, req_ready_a);
    end
    repeat (3) @(negedge clk);
    #1;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL rt_write: no write observed, required %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_err++; $display("FAIL rt_write: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (obs_a.size() != 0) begin n_err++; $display("FAIL rt_extra: %0d extra writes, required 0", obs_a.size()); obs_a.delete(); end
  endtask

  task automatic test_req_during_run();
    bit ok, seen_ready;
    logic [15:0] e, g;
    exp_a.push_back(16'h1280); exp_a.push_back(16'h3A04); exp_a.push_back(16'h1122);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); req_valid = 1'b1; req_reg = 8'h11; req_val = 8'h22;
    seen_ready = 1'b0; ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (cfg_done_a) begin ok = 1'b1; break; end
      if (req_ready_a) seen_ready = 1'b1;
    end
    n_cmp++;
    if (seen_ready) begin n_err++; $display("FAIL run_ready: o_req_ready=1 during run, required 0"); end
    n_cmp++;
    if (!ok || req_ready_a !== 1'b1) begin
      n_err++; $display("FAIL run_then_ready: done=%b rdy=%b, required 1/1", ok, req_ready_a);
    end
    @(negedge clk); req_valid = 1'b0;
    wait_ready_a(100, ok);
    repeat (3) @(negedge clk);
    #1;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL held_write: no write observed, required %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_err++; $display("FAIL held_write: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (obs_a.size() != 0) begin n_err++; $display("FAIL held_extra: %0d extra writes, required 0", obs_a.size()); obs_a.delete(); end
  endtask

  task automatic test_collision();
    bit ok;
    logic [15:0] e, g;
    @(negedge clk); start_a = 1'b0;
    exp_a.push_back(16'h1280); exp_a.push_back(16'h3A04);
    @(negedge clk); start_a = 1'b1; req_valid = 1'b1; req_reg = 8'h77; req_val = 8'h66;
    #1;
    n_cmp++;
    if (req_ready_a !== 1'b0) begin n_err++; $display("FAIL coll_ready: got %b required 0", req_ready_a); end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({cfg_done_a, addr_a, cfg_busy_a} !== {1'b0, 8'h00, 1'b1}) begin
      n_err++; $display("FAIL coll_restart: done=%b addr=%h busy=%b, required 0/00/1", cfg_done_a, addr_a, cfg_busy_a);
    end
    req_valid = 1'b0;
    wait_ready_a(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL coll_done: timed out, done=%b required 1", cfg_done_a); end
    repeat (15) @(negedge clk);
    #1;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL coll_write: no write observed, required %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_err++; $display("FAIL coll_write: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (obs_a.size() != 0) begin n_err++; $display("FAIL coll_extra: %0d extra writes, required 0", obs_a.size()); obs_a.delete(); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    logic [15:0] e, g;
    @(negedge clk); start_a = 1'b0;
    exp_a.push_back(16'h1280);
    @(negedge clk); start_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wr_start_a) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstw_start: no o_wr_start seen, required 1"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start_a = 1'b0;
    #1;
    n_cmp++;
    if ({addr_a, wr_start_a, wr_reg_a, wr_val_a, req_ready_a, cfg_done_a, cfg_busy_a} !== 27'd0) begin
      n_err++;
      $display("FAIL rstw_outputs: addr=%h start=%b reg=%h val=%h rdy=%b done=%b busy=%b, required all 0",
               addr_a, wr_start_a, wr_reg_a, wr_val_a, req_ready_a, cfg_done_a, cfg_busy_a);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    n_cmp++;
    if (cfg_busy_a !== 1'b0 || cfg_done_a !== 1'b0) begin
      n_err++; $display("FAIL rstw_idle: busy=%b done=%b, required 0/0", cfg_busy_a, cfg_done_a);
    end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL rstw_write: no write observed, required %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_err++; $display("FAIL rstw_write: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (obs_a.size() != 0) begin n_err++; $display("FAIL rstw_extra: %0d writes without start, required 0", obs_a.size()); obs_a.delete(); end
    exp_a.push_back(16'h1280); exp_a.push_back(16'h3A04);
    @(negedge clk); start_a = 1'b1;
    wait_ready_a(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstw_rerun: timed out, done=%b required 1", cfg_done_a); end
    repeat (15) @(negedge clk);
    #1;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front(); n_cmp++;
      if (obs_a.size() == 0) begin n_err++; $display("FAIL rerun_write: no write observed, required %h", e); end
      else begin
        g = obs_a.pop_front();
        if (g !== e) begin n_err++; $display("FAIL rerun_write: got %h required %h", g, e); end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] e, g;
    for (int i = 0; i < 4; i++) exp_b.push_back(rom_b[i]);
    @(negedge clk); start_b = 1'b1;
    wait_ready_b(500, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wrap_done: timed out, done=%b required 1", cfg_done_b); end
    repeat (15) @(negedge clk);
    #1;
    n_cmp++;
    if (cfg_done_b !== 1'b1 || addr_b !== 2'd0) begin
      n_err++; $display("FAIL wrap_state: done=%b addr=%0d, required 1/0", cfg_done_b, addr_b);
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front(); n_cmp++;
      if (obs_b.size() == 0) begin n_err++; $display("FAIL wrap_write: no write observed, required %h", e); end
      else begin
        g = obs_b.pop_front();
        if (g !== e) begin n_err++; $display("FAIL wrap_write: got %h required %h", g, e); end
      end
    end
    n_cmp++;
    if (obs_b.size() != 0) begin n_err++; $display("FAIL wrap_extra: %0d extra writes, required 0", obs_b.size()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_a[i] = 16'h0000;
    rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h3A04; rom_a[3] = 16'hFFFF;
    rom_b[0] = 16'h0101; rom_b[1] = 16'h0202; rom_b[2] = 16'h0303; rom_b[3] = 16'h0404;
    test_reset();
    test_table();
    test_runtime();
    test_req_during_run();
    test_collision();
    test_reset_mid_wait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
